// File: rtl/clk_sel_ctrl_if.sv
// clk_sel_ctrl_if: rate-change request/response bundle for clk_sel_ctrl
// master: requester, drives req, req_option (and lock)
// slave : clk_sel_ctrl, drives ack, busy, active_option, tick (and nack)
// lock/nack exist only when CLK_SEL_LOCK_EN is defined
interface clk_sel_ctrl_if;
   logic       req;
   logic [1:0] req_option;
   logic       ack;
   logic       busy;
   logic [1:0] active_option;
   logic       tick;
`ifdef CLK_SEL_LOCK_EN
   logic       lock;
   logic       nack;
   modport master (output req, req_option, lock, input ack, busy, active_option, tick, nack);
   modport slave  (input req, req_option, lock, output ack, busy, active_option, tick, nack);
`else
   modport master (output req, req_option, input ack, busy, active_option, tick);
   modport slave  (input req, req_option, output ack, busy, active_option, tick);
`endif
endinterface

// File: rtl/clk_sel_ctrl.sv
// clk_sel_ctrl: selects one of four divide ratios and emits a tick at that rate, switching only on a terminal count
// sys_clk : single rising-edge clock
// rst_n   : synchronous active-low reset
// bus     : clk_sel_ctrl_if.slave (req/req_option in; ack/busy/active_option/tick out)
// Optional CLK_SEL_LOCK_EN adds lock (rejects new requests) and nack
module clk_sel_ctrl #(
   parameter int DIV0  = 2,
   parameter int DIV1  = 4,
   parameter int DIV2  = 8,
   parameter int DIV3  = 16,
   parameter int CNT_W = 16
) (
   input logic           sys_clk,
   input logic           rst_n,
   clk_sel_ctrl_if.slave bus
);
   typedef enum logic [1:0] {IDLE, PEND, DONE} state_t;
   // divisors of 0 or 1 both mean "tick every cycle"
   localparam logic [CNT_W-1:0] D0 = CNT_W'((DIV0 < 2) ? 1 : DIV0);
   localparam logic [CNT_W-1:0] D1 = CNT_W'((DIV1 < 2) ? 1 : DIV1);
   localparam logic [CNT_W-1:0] D2 = CNT_W'((DIV2 < 2) ? 1 : DIV2);
   localparam logic [CNT_W-1:0] D3 = CNT_W'((DIV3 < 2) ? 1 : DIV3);
   state_t           r_state, w_nxt;
   logic [CNT_W-1:0] r_cnt, w_diva;
   logic [1:0]       r_pending, r_active;
   logic             r_tick, r_ack, r_busy, w_term, w_accept;
`ifdef CLK_SEL_LOCK_EN
   logic             r_nack;
   assign w_accept = (r_state == IDLE) && bus.req && !bus.lock;
   assign bus.nack = r_nack;
`else
   assign w_accept = (r_state == IDLE) && bus.req;
`endif
   always_comb begin
      w_diva = (r_active == 2'd0) ? D0 : (r_active == 2'd1) ? D1 : (r_active == 2'd2) ? D2 : D3;
      w_term = (r_cnt == w_diva - CNT_W'(1));
      // PEND is entered after the acceptance edge, so a terminal count coinciding with acceptance is never used
      w_nxt  = w_accept ? PEND : (r_state == PEND && w_term) ? DONE : (r_state == DONE) ? IDLE : r_state;
   end
   always_ff @(posedge sys_clk) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_active  <= 2'd0;
         r_pending <= 2'd0;
         r_tick    <= 1'b0;
         r_ack     <= 1'b0;
         r_busy    <= 1'b0;
`ifdef CLK_SEL_LOCK_EN
         r_nack    <= 1'b0;
`endif
      end else begin
         r_state <= w_nxt;
         r_busy  <= (w_nxt == PEND);
         r_ack   <= (w_nxt == DONE);
         r_tick  <= w_term;
         // the switch lands on a wrap, so the counter restarts at 0 under the new divisor either way
         r_cnt   <= w_term ? '0 : r_cnt + CNT_W'(1);
         if (w_accept) r_pending <= bus.req_option;
         if (r_state == PEND && w_term) r_active <= r_pending;
`ifdef CLK_SEL_LOCK_EN
         r_nack  <= (r_state == IDLE) && bus.req && bus.lock;
`endif
      end
   end
   assign bus.tick          = r_tick;
   assign bus.ack           = r_ack;
   assign bus.busy          = r_busy;
   assign bus.active_option = r_active;
endmodule

// File: tb/tb_clk_sel_ctrl.sv
// tb_clk_sel_ctrl: directed bench for clk_sel_ctrl with default divisors 2/4/8/16
module tb_clk_sel_ctrl;
   logic sys_clk = 1'b0;
   logic rst_n   = 1'b0;
   int   n_chk   = 0;
   int   n_fail  = 0;
   int   n_ack   = 0;
   clk_sel_ctrl_if bus();
   clk_sel_ctrl #(.DIV0(2), .DIV1(4), .DIV2(8), .DIV3(16), .CNT_W(16)) dut (
      .sys_clk(sys_clk),
      .rst_n  (rst_n),
      .bus    (bus.slave)
   );
   always #5 sys_clk = ~sys_clk;
   task automatic check(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask
   task automatic step();
      @(negedge sys_clk);
      if (bus.ack) n_ack++;
   endtask
   task automatic wait_tick(output int n);
      n = 0;
      do begin
         step();
         n++;
      end while (!bus.tick && n < 64);
   endtask
   initial begin
      int n, errs, quiet, ticks, nb, a0;
      bus.req = 1'b0;
      bus.req_option = 2'b00;
`ifdef CLK_SEL_LOCK_EN
      bus.lock = 1'b0;
`endif
      repeat (3) step();
      check("rst_tick", bus.tick, 0);
      check("rst_ack", bus.ack, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_active", bus.active_option, 0);
`ifdef CLK_SEL_LOCK_EN
      check("rst_nack", bus.nack, 0);
`endif
      rst_n = 1'b1;
      step();
      check("first_tick_early", bus.tick, 0);
      step();
      check("first_tick_div0", bus.tick, 1);
      errs = 0; quiet = 0; ticks = 0;
      for (int i = 3; i <= 66; i++) begin
         step();
         if (bus.tick !== ((i % 2) == 0)) errs++;
         if (bus.tick) ticks++;
         if (bus.ack || bus.busy || bus.active_option != 2'd0) quiet++;
      end
      check("idle_tick_pattern", errs, 0);
      check("idle_tick_count", ticks, 32);
      check("idle_quiet", quiet, 0);
      bus.req = 1'b1; bus.req_option = 2'b11;
      step();
      check("sw11_busy", bus.busy, 1);
      check("sw11_no_ack_yet", bus.ack, 0);
      bus.req = 1'b0;
      step();
      check("sw11_ack", bus.ack, 1);
      check("sw11_busy_clear", bus.busy, 0);
      check("sw11_active", bus.active_option, 3);
      check("sw11_old_tick", bus.tick, 1);
      wait_tick(n);
      check("sw11_first_period", n, 16);
      check("sw11_ack_gone", bus.ack, 0);
      wait_tick(n);
      check("sw11_period", n, 16);
      repeat (3) step();
      a0 = n_ack;
      bus.req = 1'b1; bus.req_option = 2'b00;
      step();
      nb = 0;
      bus.req_option = 2'b10;
      while (bus.busy && nb < 40) begin
         nb++;
         step();
      end
      bus.req = 1'b0;
      check("sw00_busy_cycles", nb, 12);
      check("sw00_ack", bus.ack, 1);
      check("sw00_busy_clear", bus.busy, 0);
      check("sw00_active", bus.active_option, 0);
      wait_tick(n);
      check("sw00_first_period", n, 2);
      wait_tick(n);
      check("sw00_period", n, 2);
      check("second_req_ignored", bus.active_option, 0);
      check("single_ack", n_ack - a0, 1);
      bus.req = 1'b1; bus.req_option = 2'b00;
      step();
      check("same_busy", bus.busy, 1);
      bus.req = 1'b0;
      step();
      check("same_ack", bus.ack, 1);
      check("same_tick", bus.tick, 1);
      wait_tick(n);
      check("same_period", n, 2);
      step();
      bus.req = 1'b1; bus.req_option = 2'b01;
      step();
      check("term_req_busy", bus.busy, 1);
      check("term_req_tick", bus.tick, 1);
      bus.req = 1'b0;
      step();
      check("term_req_no_early_ack", bus.ack, 0);
      step();
      check("term_req_ack", bus.ack, 1);
      check("term_req_active", bus.active_option, 1);
      wait_tick(n);
      check("term_req_period", n, 4);
      bus.req = 1'b1; bus.req_option = 2'b11;
      step();
      check("rstpend_busy", bus.busy, 1);
      bus.req = 1'b0;
      rst_n = 1'b0;
      a0 = n_ack;
      step();
      rst_n = 1'b1;
      check("rstpend_busy_clear", bus.busy, 0);
      check("rstpend_active", bus.active_option, 0);
      check("rstpend_tick", bus.tick, 0);
      wait_tick(n);
      check("rstpend_first_period", n, 2);
      wait_tick(n);
      check("rstpend_period", n, 2);
      check("rstpend_no_ack", n_ack - a0, 0);
`ifdef CLK_SEL_LOCK_EN
      bus.lock = 1'b1; bus.req = 1'b1; bus.req_option = 2'b01;
      step();
      check("lock_nack", bus.nack, 1);
      check("lock_no_busy", bus.busy, 0);
      bus.lock = 1'b0; bus.req = 1'b0;
      step();
      check("lock_nack_pulse", bus.nack, 0);
      check("lock_active", bus.active_option, 0);
      check("lock_no_ack", bus.ack, 0);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL timeout got=0 exp=1");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/clk_sel_ctrl.md
CLK_SEL_CTRL -- requirements
Module: clk_sel_ctrl

Interface
REQ-001 Parameter DIV0, default 2, sys_clk cycles per tick for option 2'b00.
REQ-002 Parameter DIV1, default 4, sys_clk cycles per tick for option 2'b01.
REQ-003 Parameter DIV2, default 8, sys_clk cycles per tick for option 2'b10.
REQ-004 Parameter DIV3, default 16, sys_clk cycles per tick for option 2'b11.
REQ-005 Parameter CNT_W, default 16, divide counter width; every DIVn SHALL be below 2**CNT_W.
REQ-006 sys_clk  input  1  single clock; all logic SHALL be rising-edge sys_clk.
REQ-007 rst_n  input  1  synchronous, active-low reset.
REQ-008 req  input  1  request to change rate; level, sampled each cycle.
REQ-009 req_option  input  2  requested option, valid while req=1.
REQ-010 ack  output  1  one-cycle pulse, request completed.
REQ-011 busy  output  1  request accepted, not yet completed.
REQ-012 active_option  output  2  option currently driving tick; feeds clk_decoder usr_option.
REQ-013 tick  output  1  registered one-cycle enable at the active divided rate.

Function
REQ-014 FSM states: IDLE, PEND, DONE; all outputs SHALL be registered.
REQ-015 Counter cnt SHALL count 0..DIVa-1 (DIVa = divisor of active_option), then wrap to 0.
REQ-016 tick SHALL be 1 in the cycle after cnt = DIVa-1, i.e. one pulse every DIVa cycles.
REQ-017 DIVn of 0 or 1 SHALL be treated as 1: tick is high every cycle.
REQ-018 IDLE with req=1: latch req_option into pending, go to PEND; busy=1 from next cycle.
REQ-019 PEND: on cnt = DIVa-1, next cycle active_option<=pending, cnt<=0, go to DONE.
REQ-020 DONE: ack=1 and busy=0 for exactly one cycle, then IDLE; req is ignored in DONE.
REQ-021 A new request SHALL be accepted only from IDLE; req in PEND/DONE is ignored.
REQ-022 req_option equal to active_option SHALL still complete via PEND/DONE, with no counter restart and no tick-period change.
REQ-023 req in IDLE in the same cycle as cnt = DIVa-1: switch SHALL occur at the following terminal count, never the same one.
REQ-024 Option change SHALL never produce a tick period shorter than min(old DIV, new DIV).
REQ-025 The first tick after a switch SHALL come DIVnew cycles after the switch cycle.

Reset
REQ-026 rst_n=0 at a sys_clk edge: state IDLE, cnt 0, active_option 2'b00, pending 2'b00, tick 0, ack 0, busy 0.
REQ-027 Reset during PEND or DONE SHALL discard the pending request with no ack.
REQ-028 After rst_n rises, the first tick SHALL come DIV0 cycles later.

Configuration
REQ-029 Macro CLK_SEL_LOCK_EN defined: add input lock (1 bit) and output nack (1 bit).
REQ-030 With the macro, req in IDLE while lock=1 SHALL give a one-cycle nack next cycle and leave state and active_option unchanged.
REQ-031 With the macro, lock SHALL NOT affect a request already in PEND.
REQ-032 nack SHALL reset to 0.
REQ-033 Without the macro, the lock and nack ports SHALL not exist and requests are never rejected.

Verification
REQ-034 Reset, then hold idle 64 cycles -> tick every 2 cycles, active_option=00, ack=0, busy=0.
REQ-035 req=1, req_option=11 pulsed at cnt=0 under option 00 -> switch at next terminal count, ack pulse, then tick period 16.
REQ-036 Option 11, req to 00 at cnt=3 -> busy held to cnt=15, ack one cycle, next tick 2 cycles after the switch.
REQ-037 Second req (option 10) during PEND -> ignored; only the first option applied, a single ack.
REQ-038 rst_n=0 for 1 cycle during PEND -> no ack, active_option=00, tick every 2 cycles resumes.
REQ-039 CLK_SEL_LOCK_EN build, lock=1, req option 01 -> nack next cycle, no busy, active_option unchanged.
